uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmitter: serializes one parallel byte into a frame of start bit, data LSB-first, optional parity bit and stop bit, on a single serial line.
- Sits directly upstream of the UART receiver. TX_OUT drives the receiver's RX_IN.
- CLK runs at the baud rate, so one frame bit is transmitted per CLK cycle.
- Frame format (parity enable and parity type) matches the receiver's PAR_EN/PAR_TYP semantics exactly.

Parameters:
- DATA_WIDTH, 8: number of data bits per frame.

Ports:
- CLK  input  1  baud-rate clock; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  byte to transmit; sampled on acceptance.
- DATA_VALID  input  1  request to send P_DATA; accepted only when Busy=0.
- PAR_EN  input  1  1 = parity bit inserted between data and stop.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; ignored if PAR_EN=0.
- TX_OUT  output  1  serial line, registered, idles high.
- Busy  output  1  registered; high while a frame is on the line.

Behaviour:
- Reset (async, RST=1):
  - TX_OUT=1, Busy=0, FSM=IDLE.
  - Bit counter, shift register and latched config cleared.
  - Asserting RST mid-frame aborts the frame immediately; no partial stop bit is sent.
  - After release, the block waits for a new DATA_VALID.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, Busy=0.
  - If DATA_VALID=1 on a rising edge, latch P_DATA, PAR_EN and PAR_TYP, compute the parity bit, and go to START.
- START: TX_OUT=0 and Busy=1 for exactly one cycle. Next state is DATA.
- DATA:
  - TX_OUT = latched bit[i], i = 0..DATA_WIDTH-1 (LSB first), one cycle per bit.
  - Bit counter width is clog2(DATA_WIDTH).
  - After bit DATA_WIDTH-1: go to PARITY if the latched PAR_EN=1, else go to STOP.
- PARITY:
  - Even parity: TX_OUT = XOR of the latched data bits (total number of ones, including the parity bit, is even).
  - Odd parity: TX_OUT = XNOR of the latched data bits.
  - Lasts one cycle, then go to STOP.
- STOP: TX_OUT=1 and Busy=1 for one cycle. Next state is IDLE.
- Latency:
  - The start bit appears on TX_OUT the cycle after the acceptance edge.
  - Frame length is 1+DATA_WIDTH+PAR_EN+1 cycles (10 or 11 for DATA_WIDTH=8).
  - Busy is high for exactly that many cycles.
- Inter-frame spacing: acceptance happens only in IDLE, so back-to-back frames are separated by at least one idle-high cycle.
- DATA_VALID handling:
  - DATA_VALID while Busy=1 is ignored; it is not queued and is not an error.
  - The source must hold or re-present DATA_VALID until it sees Busy=0.
- Config changes: changes to P_DATA, PAR_EN or PAR_TYP during a frame have no effect on that frame.
- DATA_VALID held continuously high: frames repeat with exactly one idle cycle between stop and the next start.
- TX_OUT never glitches: it comes only from a register and changes only on the clock edge or on reset.

Test Plan:
- Reset then idle 5 cycles with DATA_VALID=0 -> TX_OUT=1 and Busy=0 throughout.
- P_DATA=0xA5, PAR_EN=0, single-cycle DATA_VALID -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1; Busy high for exactly 10 cycles.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> 0,1,0,1,0,0,1,0,1,0,1, i.e. even parity bit 0; 11-cycle Busy.
- P_DATA=0x00, PAR_EN=1, PAR_TYP=1 -> eight 0 data bits, parity bit 1, stop bit 1.
- P_DATA=0x3C sent with DATA_VALID held high; P_DATA changed to 0xFF mid-frame -> first frame carries 0x3C, one idle cycle follows, second frame carries 0xFF.
- RST pulsed during data bit 4 of 0x0F -> TX_OUT=1 and Busy=0 immediately. Next request for 0x81 produces a clean full frame.
- Loopback: TX_OUT connected to the receiver's RX_IN with matching PAR_EN/PAR_TYP. For 20 random bytes, the receiver's P_DATA equals the sent byte and data_valid pulses once per frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, stop bit; one bit per CLK.
// TX_OUT and Busy are registered from the next state, so the start bit appears on the cycle after acceptance.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;

    case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          // Odd parity is the complement of the even-parity bit.
          par_bit_d = (^P_DATA) ^ PAR_TYP;
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded with the value belonging to the state being entered.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      IDLE:    busy_d = 1'b0;
      START:   tx_d   = 1'b0;
      DATA:    tx_d   = data_d[cnt_d];
      PARITY:  tx_d   = par_bit_d;
      STOP:    tx_d   = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule
